// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with storage, FWFT/registered read, status flags,
// occupancy count, overflow/underflow pulses and synchronous flush.
//
// Ports:
//   i_clk, i_rst (async assert, sync release), i_clr (sync flush)
//   i_wr_en/i_wr_data   write side
//   i_rd_en/o_rd_data/o_rd_valid   read side
//   o_full, o_empty, o_almost_full, o_almost_empty, o_count   status
//   o_overflow, o_underflow   one-cycle error pulses
module sync_fifo_ctrl #(
    parameter int DataWidth         = 16,
    parameter int Depth             = 16,
    parameter int Fwft              = 1,
    parameter int AlmostFullThresh  = Depth - 2,
    parameter int AlmostEmptyThresh = 2,
    localparam int CntWidth         = $clog2(Depth + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_wr_en,
    input  logic [DataWidth-1:0] i_wr_data,
    input  logic                 i_rd_en,
    output logic [DataWidth-1:0] o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
    output logic [CntWidth-1:0]  o_count,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);
    localparam logic [CntWidth-1:0] AfTh    = CntWidth'(AlmostFullThresh);
    localparam logic [CntWidth-1:0] AeTh    = CntWidth'(AlmostEmptyThresh);

    // Reset takes effect at once but is released only on a clock edge,
    // so no flop sees the release close to an active edge.
    logic rst_meta_q;
    logic rst_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_meta_q <= 1'b1;
            rst_q      <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_q      <= rst_meta_q;
        end
    end

    logic [DataWidth-1:0] mem_q [Depth];

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic full_q, empty_q, af_q, ae_q;
    logic ovf_q, unf_q;

    logic wr_acc;
    logic rd_acc;

    // A full FIFO rejects writes even when a read pops in the same cycle.
    assign wr_acc = i_wr_en && !full_q && !i_clr;
    assign rd_acc = i_rd_en && !empty_q && !i_clr;

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Explicit wrap: Depth need not be a power of two.
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PtrLast) ? '0
                         : wr_ptr_q + PtrWidth'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PtrLast) ? '0
                         : rd_ptr_q + PtrWidth'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CntWidth'(1);
                2'b01:   cnt_d = cnt_q - CntWidth'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Flags come from the next count so they line up with o_count.
    always_ff @(posedge i_clk or posedge rst_q) begin
        if (rst_q) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == CntFull);
            empty_q  <= (cnt_d == '0);
            af_q     <= (cnt_d >= AfTh);
            ae_q     <= (cnt_d <= AeTh);
            ovf_q    <= i_wr_en && full_q && !i_clr;
            unf_q    <= i_rd_en && empty_q && !i_clr;
        end
    end

    generate
        if (Fwft != 0) begin : g_fwft
            // Masked while empty so stale array words never leak out.
            assign o_rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
            assign o_rd_valid = !empty_q;
        end else begin : g_reg
            logic [DataWidth-1:0] rd_data_q;
            logic                 rd_valid_q;

            always_ff @(posedge i_clk or posedge rst_q) begin
                if (rst_q) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem_q[rd_ptr_q];
                    end
                end
            end

            assign o_rd_data  = rd_data_q;
            assign o_rd_valid = rd_valid_q;
        end
    endgenerate

    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
    assign o_count        = cnt_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

endmodule
